// File: rtl/phy_serial_pkg.sv
// Shared definitions for the PHY serial receive path: the default COM
// symbol, the receiver state encoding and the bit-counter width.
package phy_serial_pkg;

    // K28.5 comma, used both for byte alignment and as the idle filler.
    localparam logic [7:0] COM_BYTE_DEF = 8'hBC;

    // One serial byte spans eight bit clocks, so three counter bits suffice.
    localparam int BIT_CNT_W = 3;

    // Receiver state encoding.
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } rx_state_e;

    // A byte boundary is the edge that samples the LSB, i.e. the last count
    // value of the byte.
    function automatic logic at_boundary(input logic [BIT_CNT_W-1:0] cnt);
        return cnt == {BIT_CNT_W{1'b1}};
    endfunction

endpackage

// File: rtl/com_detect.sv
// Serial-to-parallel shift register with a COM comparator on the next-state
// window. Comparing the value about to be registered (rather than the
// registered value) lets the controller react on the same edge that samples
// the last bit of a symbol.
module com_detect
    import phy_serial_pkg::*;
#(
    parameter logic [7:0] COM_BYTE = COM_BYTE_DEF
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       data_i,
    output logic [7:0] nxt_o,
    output logic       com_match_o
);

    logic [7:0] sr_q;
    logic [7:0] sr_d;

    // Next window: previous seven bits with the incoming bit as new LSB.
    always_comb begin
        sr_d        = {sr_q[6:0], data_i};
        com_match_o = (sr_d == COM_BYTE);
    end

    assign nxt_o = sr_d;

    // Shift one bit per clock; reset clears the window so no stale bits
    // can form a false COM after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q <= 8'h00;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver: finds K28.5 byte alignment in an MSB-first
// bit stream, locks after COM_COUNT aligned COMs and then delivers bytes
// with a per-boundary strobe. COM bytes received while locked are treated
// as idle and flagged invalid.
//
// Build option: define RX_RELOCK_EN to let the receiver drop lock after
// MISALIGN_MAX COMs seen off the byte boundary and search for the new phase.
// Without it, LOCKED is left only through reset.
module serial_paralelo_rx
    import phy_serial_pkg::*;
#(
    parameter logic [7:0] COM_BYTE     = COM_BYTE_DEF,
    parameter int         COM_COUNT    = 4,
    parameter int         MISALIGN_MAX = 3
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active
);

    localparam logic [3:0] COM_CNT_L = 4'(COM_COUNT);
    localparam logic [3:0] MIS_MAX_L = 4'(MISALIGN_MAX);

    // Reject configurations the 4-bit counters cannot represent.
    if (COM_COUNT < 1 || COM_COUNT > 15 || MISALIGN_MAX < 1 || MISALIGN_MAX > 15) begin : g_bad_param
        $error("serial_paralelo_rx: COM_COUNT must be 1..15 and MISALIGN_MAX 1..15");
    end

    logic [7:0]           nxt;
    logic                 com_match;
    logic                 boundary;
    logic [BIT_CNT_W-1:0] bit_cnt_d;
    logic [3:0]           com_cnt_d;

    rx_state_e            state_q;
    logic [BIT_CNT_W-1:0] bit_cnt_q;
    logic [3:0]           com_cnt_q;
    logic [7:0]           data_q;
    logic                 valid_q;
    logic                 strobe_q;
    logic                 active_q;
`ifdef RX_RELOCK_EN
    logic [3:0]           misalign_cnt_q;
    logic [3:0]           misalign_cnt_d;
`endif

    com_detect #(
        .COM_BYTE (COM_BYTE)
    ) u_com_detect (
        .clk_i       (clk_32f),
        .rst_ni      (reset),
        .data_i      (data_in),
        .nxt_o       (nxt),
        .com_match_o (com_match)
    );

    // Counter increments and boundary decode feeding the controller.
    always_comb begin
        boundary  = at_boundary(bit_cnt_q);
        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        com_cnt_d = com_cnt_q + 4'd1;
`ifdef RX_RELOCK_EN
        misalign_cnt_d = misalign_cnt_q + 4'd1;
`endif
    end

    // Alignment controller with registered outputs. The bit counter runs
    // freely and wraps 7->0; it is re-zeroed only when a COM is first found.
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state_q        <= SEARCH;
            bit_cnt_q      <= '0;
            com_cnt_q      <= 4'd0;
            data_q         <= 8'h00;
            valid_q        <= 1'b0;
            strobe_q       <= 1'b0;
            active_q       <= 1'b0;
`ifdef RX_RELOCK_EN
            misalign_cnt_q <= 4'd0;
`endif
        end else begin
            bit_cnt_q <= bit_cnt_d;
            strobe_q  <= 1'b0;
            case (state_q)
                SEARCH: begin
                    if (com_match) begin
                        bit_cnt_q <= '0;
                        if (COM_COUNT == 1) begin
                            state_q   <= LOCKED;
                            com_cnt_q <= COM_CNT_L;
                            active_q  <= 1'b1;
                        end else begin
                            state_q   <= ALIGN;
                            com_cnt_q <= 4'd1;
                        end
                    end
                end
                ALIGN: begin
                    // Only boundary-aligned COMs count; mid-byte hits are noise.
                    if (boundary) begin
                        if (com_match) begin
                            if (com_cnt_d >= COM_CNT_L) begin
                                state_q   <= LOCKED;
                                com_cnt_q <= COM_CNT_L;
                                active_q  <= 1'b1;
                            end else begin
                                com_cnt_q <= com_cnt_d;
                            end
                        end else begin
                            state_q   <= SEARCH;
                            com_cnt_q <= 4'd0;
                        end
                    end
                end
                LOCKED: begin
                    if (boundary) begin
                        data_q   <= nxt;
                        strobe_q <= 1'b1;
                        valid_q  <= !com_match;
`ifdef RX_RELOCK_EN
                        if (com_match) begin
                            misalign_cnt_q <= 4'd0;
                        end
`endif
                    end
`ifdef RX_RELOCK_EN
                    else if (com_match) begin
                        // A COM off the boundary means the sender's phase moved.
                        if (misalign_cnt_d >= MIS_MAX_L) begin
                            state_q        <= SEARCH;
                            active_q       <= 1'b0;
                            valid_q        <= 1'b0;
                            strobe_q       <= 1'b0;
                            com_cnt_q      <= 4'd0;
                            misalign_cnt_q <= 4'd0;
                        end else begin
                            misalign_cnt_q <= misalign_cnt_d;
                        end
                    end
`endif
                end
                default: begin
                    state_q   <= SEARCH;
                    com_cnt_q <= 4'd0;
                    active_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign byte_strobe = strobe_q;
    assign active      = active_q;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Directed bench for serial_paralelo_rx: alignment, data delivery, idle COM
// filtering, reset behaviour, resynchronisation and the optional relock path
// (RX_RELOCK_EN).
`timescale 1ns/100ps
module tb_serial_paralelo_rx;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;

    int n_cmp = 0;
    int n_bad = 0;

    // Per-byte observation: bit i = output after the edge sampling the i-th
    // transmitted bit (bit 7 = LSB edge).
    logic [7:0] strb_mask;
    logic [7:0] act_mask;

    serial_paralelo_rx dut (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .byte_strobe (byte_strobe),
        .active      (active)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        strb_mask = 8'h00;
        act_mask  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            send_bit(b[7-i]);
            strb_mask[i] = byte_strobe;
            act_mask[i]  = active;
        end
    endtask

    task automatic pulse_reset();
        #2;
        reset = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk_32f);
        #1;
        n_cmp++;
        if ({data_out, valid_out, byte_strobe, active} !== 11'h000) begin
            n_bad++;
            $display("FAIL reset_outputs got data=%h v=%b s=%b a=%b want all zero",
                     data_out, valid_out, byte_strobe, active);
        end
        reset = 1'b1;
    endtask

    task automatic test_lock();
        logic [7:0] exp_act [4] = '{8'h00, 8'h00, 8'h00, 8'h80};
        for (int k = 0; k < 4; k++) begin
            send_byte(8'hBC);
            n_cmp++;
            if (act_mask !== exp_act[k]) begin
                n_bad++;
                $display("FAIL lock_active_com%0d got %h want %h", k, act_mask, exp_act[k]);
            end
            n_cmp++;
            if (strb_mask !== 8'h00) begin
                n_bad++;
                $display("FAIL lock_strobe_com%0d got %h want 00", k, strb_mask);
            end
        end
        n_cmp++;
        if (valid_out !== 1'b0) begin
            n_bad++;
            $display("FAIL lock_valid got %b want 0", valid_out);
        end
    endtask

    task automatic test_data();
        logic [7:0] bytes [2] = '{8'hA5, 8'h3C};
        for (int k = 0; k < 2; k++) begin
            send_byte(bytes[k]);
            n_cmp++;
            if (strb_mask !== 8'h80) begin
                n_bad++;
                $display("FAIL data_strobe%0d got %h want 80", k, strb_mask);
            end
            n_cmp++;
            if (data_out !== bytes[k] || valid_out !== 1'b1) begin
                n_bad++;
                $display("FAIL data_byte%0d got %h/v%b want %h/v1", k, data_out, valid_out, bytes[k]);
            end
        end
    endtask

    task automatic test_com_idle();
        send_byte(8'hBC);
        n_cmp++;
        if (strb_mask !== 8'h80) begin
            n_bad++;
            $display("FAIL idle_strobe got %h want 80", strb_mask);
        end
        n_cmp++;
        if (data_out !== 8'hBC || valid_out !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_byte got %h/v%b want bc/v0", data_out, valid_out);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_act [4] = '{8'h00, 8'h00, 8'h00, 8'h80};
        send_byte(8'h5A);
        n_cmp++;
        if (data_out !== 8'h5A || valid_out !== 1'b1 || active !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset got %h/v%b/a%b want 5a/v1/a1", data_out, valid_out, active);
        end
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        #2;
        reset = 1'b0;
        #0.5;
        n_cmp++;
        if ({data_out, valid_out, byte_strobe, active} !== 11'h000) begin
            n_bad++;
            $display("FAIL midbyte_reset got data=%h v=%b s=%b a=%b want all zero",
                     data_out, valid_out, byte_strobe, active);
        end
        #0.5;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send_byte(8'hBC);
            n_cmp++;
            if (act_mask !== exp_act[k] || strb_mask !== 8'h00) begin
                n_bad++;
                $display("FAIL relock_com%0d got act=%h strb=%h want act=%h strb=00",
                         k, act_mask, strb_mask, exp_act[k]);
            end
        end
    endtask

    task automatic test_resync();
        logic [7:0] seq     [8] = '{8'hBC, 8'hBC, 8'hBC, 8'h00, 8'hBC, 8'hBC, 8'hBC, 8'hBC};
        logic [7:0] exp_act [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
        pulse_reset();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        n_cmp++;
        if (active !== 1'b0) begin
            n_bad++;
            $display("FAIL resync_garbage got a=%b want 0", active);
        end
        for (int k = 0; k < 8; k++) begin
            send_byte(seq[k]);
            n_cmp++;
            if (act_mask !== exp_act[k] || strb_mask !== 8'h00) begin
                n_bad++;
                $display("FAIL resync_byte%0d got act=%h strb=%h want act=%h strb=00",
                         k, act_mask, strb_mask, exp_act[k]);
            end
        end
    endtask

    task automatic test_relock();
`ifdef RX_RELOCK_EN
        logic [7:0] exp_act  [7] = '{8'hFF, 8'hFF, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h80};
        logic [7:0] exp_strb [7] = '{8'h40, 8'h40, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
`else
        logic [7:0] exp_act  [7] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        logic [7:0] exp_strb [7] = '{8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40};
`endif
        send_bit(1'b0);
        for (int k = 0; k < 7; k++) begin
            send_byte(8'hBC);
            n_cmp++;
            if (act_mask !== exp_act[k] || strb_mask !== exp_strb[k]) begin
                n_bad++;
                $display("FAIL shift_com%0d got act=%h strb=%h want act=%h strb=%h",
                         k, act_mask, strb_mask, exp_act[k], exp_strb[k]);
            end
`ifdef RX_RELOCK_EN
            if (k == 2) begin
                n_cmp++;
                if (valid_out !== 1'b0 || byte_strobe !== 1'b0) begin
                    n_bad++;
                    $display("FAIL unlock_outputs got v=%b s=%b want v0 s0", valid_out, byte_strobe);
                end
            end
`endif
        end
        send_byte(8'hA5);
`ifdef RX_RELOCK_EN
        n_cmp++;
        if (strb_mask !== 8'h80 || data_out !== 8'hA5 || valid_out !== 1'b1) begin
            n_bad++;
            $display("FAIL new_phase got strb=%h data=%h v=%b want 80/a5/1", strb_mask, data_out, valid_out);
        end
`else
        n_cmp++;
        if (strb_mask !== 8'h40 || data_out !== 8'h52 || valid_out !== 1'b1 || active !== 1'b1) begin
            n_bad++;
            $display("FAIL sticky_lock got strb=%h data=%h v=%b a=%b want 40/52/1/1",
                     strb_mask, data_out, valid_out, active);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_lock();
        test_data();
        test_com_idle();
        test_reset_mid();
        test_resync();
        test_relock();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
